shifter_right_seq: RTL and testbench

- Multi-cycle logical/arithmetic right shifter for the MIPS pipeline EX stage.
- Complements the combinational SLL unit and covers SRL and SRA.
- Shifts one binary stage per clock, 1/2/4/8/16 bits, so the path is a single mux level per cycle.
- Uses a start/busy/done handshake with the hazard/stall logic.

---
 rtl/shifter_right_seq.sv | 195 +++++++++++++++++++
 tb/tb_shifter_right_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shifter_right_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// shifter_right_seq
//
// Multi-cycle right shifter for the EX stage. It covers SRL (logical) and SRA
// (arithmetic) and applies one binary stage per clock (1, 2, 4, 8, then 16
// bits). Each cycle is therefore a single 2:1 mux level.
//
// Optional rotate: define SHIFTER_RIGHT_ROTATE_EN to accept ROTR
// (Signal = 6'b000110). Without the macro, ROTR takes the error path.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request pulse, sampled only in IDLE or DONE
//   A        in   [WIDTH-1:0] operand
//   B        in   [WIDTH-1:0] shift amount; all bits are examined
//   Signal   in   [5:0] funct code (SRL=000010, SRA=000011)
//   busy     out  high while a shift is in progress
//   done     out  one-cycle pulse when dataOut becomes valid
//   dataOut  out  [WIDTH-1:0] result, held until the next result is written
//   err      out  high together with done for an unsupported funct code
//
// Timing: a start accepted at edge T gives busy during T+1..T+5. done is
// high during T+6, and dataOut is valid from T+6.
// -----------------------------------------------------------------------------
module shifter_right_seq #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             err
);

    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
`ifdef SHIFTER_RIGHT_ROTATE_EN
    localparam logic [5:0] OP_ROTR = 6'b000110;
`endif
    localparam logic [2:0] K_LAST = 3'(STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [STAGES-1:0]  amt_q, amt_d;
    logic               over_q, over_d;
    logic               fill_q, fill_d;
    logic               rot_q, rot_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic               is_rotr;
    logic               op_valid;
    logic               accept;
    logic [WIDTH-1:0]   stage_res [STAGES];
    logic [WIDTH-1:0]   stage_out;

`ifdef SHIFTER_RIGHT_ROTATE_EN
    assign is_rotr = (Signal == OP_ROTR);
`else
    assign is_rotr = 1'b0;
`endif

    assign op_valid = (Signal == OP_SRL) || (Signal == OP_SRA) || is_rotr;

    // A new request is only looked at when no shift is running.
    assign accept = start && (state_q != ST_SHIFT);

    // Build one candidate result per stage. Stage gi moves the data by 2^gi
    // bits. The vacated bits take the fill value, or for a rotate they take
    // the bits that fell off the right-hand end.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage_res[gi] = rot_q ? {work_q[SH-1:0], work_q[WIDTH-1:SH]}
                                         : {{SH{fill_q}}, work_q[WIDTH-1:SH]};
        end
    endgenerate

    // Pick the candidate for the current stage. If that bit of the shift
    // amount is 0, pass the work register through unchanged.
    assign stage_out = amt_q[k_q] ? stage_res[k_q] : work_q;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            work_q  <= '0;
            amt_q   <= '0;
            over_q  <= 1'b0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            over_q  <= over_d;
            fill_q  <= fill_d;
            rot_q   <= rot_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = op_valid ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_comb begin
        k_d    = k_q;
        work_d = work_q;
        amt_d  = amt_q;
        over_d = over_q;
        fill_d = fill_q;
        rot_d  = rot_q;
        data_d = data_q;
        err_d  = 1'b0;      // err is high only during the DONE cycle it belongs to
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (op_valid) begin
                        k_d    = '0;
                        work_d = A;
                        amt_d  = B[STAGES-1:0];
                        // A rotate wraps its amount, so the out-of-range
                        // flag is never set for it.
                        over_d = (|B[WIDTH-1:STAGES]) && !is_rotr;
                        fill_d = (Signal == OP_SRA) ? A[WIDTH-1] : 1'b0;
                        rot_d  = is_rotr;
                    end else begin
                        data_d = '0;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    // When the amount is out of range, the operand is fully
                    // shifted out. Only the fill value remains.
                    data_d = over_q ? {WIDTH{fill_q}} : stage_out;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // All outputs come from flops, so no input reaches an output combinationally.
    always_comb begin
        busy    = (state_q == ST_SHIFT);
        done    = (state_q == ST_DONE);
        dataOut = data_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_shifter_right_seq.sv
`timescale 1ns/1ps
module tb_shifter_right_seq;

    localparam logic [5:0] SRL  = 6'b000010;
    localparam logic [5:0] SRA  = 6'b000011;
    localparam logic [5:0] ROTR = 6'b000110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] A, B;
    logic [5:0]  Signal;
    logic        busy, done, err;
    logic [31:0] dataOut;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shifter_right_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model built from the arithmetic meaning of each operation.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [5:0] sig,
                                  output logic [31:0] d, output logic e);
        logic [63:0] dbl;
        e = 1'b0;
        d = '0;
        case (sig)
            SRL: d = (b >= 32) ? 32'h0 : (a >> b);
            SRA: d = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
`ifdef SHIFTER_RIGHT_ROTATE_EN
            ROTR: begin
                dbl = {a, a} >> b[4:0];
                d   = dbl[31:0];
            end
`endif
            default: begin
                e = 1'b1;
                d = '0;
            end
        endcase
    endfunction

    // Call in mid-cycle while the DUT is in IDLE or DONE. The task returns
    // during the done cycle, or during cycle T+1 on the error path.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] sig, input bit spurious);
        logic [31:0] exp_d;
        logic        exp_e;
        model(a, b, sig, exp_d, exp_e);
        start = 1'b1; A = a; B = b; Signal = sig;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; Signal = 6'($urandom);
        if (!exp_e) begin
            for (int i = 1; i <= 5; i++) begin
                check("busy_during_shift", 32'(busy), 32'd1);
                check("no_done_during_shift", 32'(done), 32'd0);
                if (spurious && i == 2) begin
                    start = 1'b1; A = 32'h1; B = 32'h1; Signal = SRL;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("err_flag", 32'(err), 32'(exp_e));
        check("data_out", dataOut, exp_d);
        $display("op sig=%b a=%h b=%h -> data=%h err=%b (exp %h/%b)",
                 sig, a, b, dataOut, err, exp_d, exp_e);
    endtask

    // Move one cycle on from DONE into IDLE and confirm that the result is held.
    task automatic idle_hold(input logic [31:0] exp_d);
        @(posedge clk); #1;
        check("done_single_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("data_held", dataOut, exp_d);
    endtask

    initial begin
        logic [31:0] ra, rb, ed;
        logic [5:0]  rs;
        logic        ee;

        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; Signal = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_data", dataOut, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(32'hF000_0000, 32'd4, SRL, 1'b0);           idle_hold(32'h0F00_0000);
        do_op(32'h8000_0010, 32'd31, SRA, 1'b0);          idle_hold(32'hFFFF_FFFF);
        do_op(32'h4000_0000, 32'd1, SRA, 1'b0);           idle_hold(32'h2000_0000);
        do_op(32'hFFFF_FFFF, 32'd32, SRL, 1'b0);          idle_hold(32'h0);
        do_op(32'h8000_0000, 32'h0000_0100, SRA, 1'b0);   idle_hold(32'hFFFF_FFFF);
        do_op(32'h1234_5678, 32'd0, SRL, 1'b0);           idle_hold(32'h1234_5678);

        // A start pulsed mid-shift is ignored. A start during DONE is accepted.
        do_op(32'h0000_FF00, 32'd8, SRL, 1'b1);
        do_op(32'hF000_0000, 32'd4, SRA, 1'b0);           idle_hold(32'hFF00_0000);

        // Asserting reset mid-shift aborts the operation immediately.
        start = 1'b1; A = 32'hDEAD_BEEF; B = 32'd3; Signal = SRL;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", dataOut, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", 32'(done), 32'd0);
        end

        // Error path and optional rotate
        do_op(32'hABCD_0123, 32'd5, 6'b100000, 1'b0);     idle_hold(32'h0);
        do_op(32'h0000_0001, 32'd1, ROTR, 1'b0);
        model(32'h0000_0001, 32'd1, ROTR, ed, ee);
        idle_hold(ed);

        // Randomized operations with some back-to-back chaining
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 31));
                1: rb = $urandom;
                2: rb = 32'($urandom_range(28, 40));
                default: rb = 32'($urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 4))
                0, 1: rs = SRL;
                2, 3: rs = SRA;
                default: rs = ($urandom_range(0, 1) != 0) ? ROTR : 6'($urandom);
            endcase
            do_op(ra, rb, rs, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) != 0) begin
                model(ra, rb, rs, ed, ee);
                idle_hold(ed);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
